// File: rtl/cond_inc_pkg.sv
// Shared types and default sizing for the bounded conditional-increment iterator.
package cond_inc_pkg;

  localparam int unsigned WIDTH_DEF     = 32;
  localparam int unsigned THRESHOLD_DEF = 4096;
  localparam int unsigned MAX_STEPS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to hold a step count in the range 0..max_steps.
  function automatic int unsigned step_w(input int unsigned max_steps);
    return $clog2(max_steps + 1);
  endfunction

endpackage

// File: rtl/cond_increment_iter_if.sv
// Operand-in / result-out handshake bundle for cond_increment_iter.
interface cond_increment_iter_if
  import cond_inc_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STEP_W = step_w(MAX_STEPS_DEF)
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [STEP_W-1:0] in_steps;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [STEP_W-1:0] out_steps;
  logic              out_saturated;

  modport master (
    output in_valid, in_data, in_steps, out_ready,
    input  in_ready, out_valid, out_data, out_steps, out_saturated
  );

  modport slave (
    input  in_valid, in_data, in_steps, out_ready,
    output in_ready, out_valid, out_data, out_steps, out_saturated
  );
endinterface

// File: rtl/cond_step.sv
// One application of f(x) = (x > THRESHOLD) ? x : x + 1, plus the saturation flag.
module cond_step #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned THRESHOLD = 4096
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] nx,
  output logic             sat
);
  always_comb begin
    sat = (x > WIDTH'(THRESHOLD));
    nx  = sat ? x : x + WIDTH'(1);
  end
endmodule

// File: rtl/cond_increment_iter.sv
// Applies the conditional increment once per clock until the step budget is spent
// or the value passes THRESHOLD, then holds the result until it is taken.
module cond_increment_iter
  import cond_inc_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned THRESHOLD = THRESHOLD_DEF,
  parameter int unsigned MAX_STEPS = MAX_STEPS_DEF,
  parameter int unsigned STEP_W    = step_w(MAX_STEPS)
) (
  input logic                  clk,
  input logic                  rst_n,
  cond_increment_iter_if.slave bus
);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  state_t            state, state_n;
  logic [WIDTH-1:0]  x, x_n;
  logic [STEP_W-1:0] left, left_n;
  logic [STEP_W-1:0] cnt, cnt_n;
  logic              in_ready, in_ready_n;
  logic              out_valid, out_valid_n;
  logic [WIDTH-1:0]  out_data, out_data_n;
  logic [STEP_W-1:0] out_steps, out_steps_n;
  logic              out_sat, out_sat_n;
  logic [WIDTH-1:0]  nx;
  logic              sat;

  cond_step #(.WIDTH(WIDTH), .THRESHOLD(THRESHOLD)) u_step (
    .x  (x),
    .nx (nx),
    .sat(sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      left      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_steps <= '0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_n;
      x         <= x_n;
      left      <= left_n;
      cnt       <= cnt_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_steps <= out_steps_n;
      out_sat   <= out_sat_n;
    end
  end

  always_comb begin
    state_n     = state;
    x_n         = x;
    left_n      = left;
    cnt_n       = cnt;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_steps_n = out_steps;
    out_sat_n   = out_sat;
    case (state)
      IDLE: begin
        in_ready_n = 1'b1;
        if (bus.in_valid && in_ready) begin
          x_n        = bus.in_data;
          left_n     = (bus.in_steps > STEP_MAX) ? STEP_MAX : bus.in_steps;
          cnt_n      = '0;
          in_ready_n = 1'b0;
          state_n    = RUN;
        end
      end
      RUN: begin
        // Stop before applying f when the budget is gone or x is already past the threshold.
        if (left == '0 || sat) begin
          out_data_n  = x;
          out_steps_n = cnt;
          out_sat_n   = sat;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end else begin
          x_n    = nx;
          left_n = left - STEP_W'(1);
          cnt_n  = cnt + STEP_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_data      = out_data;
  assign bus.out_steps     = out_steps;
  assign bus.out_saturated = out_sat;
endmodule

// File: tb/tb_cond_increment_iter.sv
// Randomised and directed checks of cond_increment_iter against a behavioural model.
module tb_cond_increment_iter;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned THRESHOLD = 4096;
  localparam int unsigned MAX_STEPS = 16;
  localparam int unsigned STEP_W    = $clog2(MAX_STEPS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  cond_increment_iter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  cond_increment_iter #(
    .WIDTH(WIDTH), .THRESHOLD(THRESHOLD), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: repeat f up to min(steps, MAX_STEPS) times, stopping once x > THRESHOLD.
  task automatic model(input longint unsigned x0, input int unsigned steps,
                       output longint unsigned xr, output int unsigned k);
    int unsigned budget;
    budget = (steps > MAX_STEPS) ? MAX_STEPS : steps;
    xr = x0;
    k  = 0;
    while (k < budget && xr <= THRESHOLD) begin
      xr = (xr + 1) % (64'd1 << WIDTH);
      k++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] d, input int unsigned s, input int unsigned hold);
    longint unsigned exp_x;
    int unsigned     exp_k;
    int unsigned     lat;
    int unsigned     w;
    logic [WIDTH-1:0] snap;
    model(d, s, exp_x, exp_k);
    w = 0;
    while (!bus.in_ready && w < 40) begin
      tick();
      w++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_steps  = STEP_W'(s);
    bus.out_ready = (hold == 0);
    tick();
    bus.in_valid = 1'b0;
    check("in_ready_busy", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_k + 1));
    check("out_data", 64'(bus.out_data), exp_x);
    check("out_steps", 64'(bus.out_steps), 64'(exp_k));
    check("out_sat", 64'(bus.out_saturated), 64'(exp_x > THRESHOLD));
    snap = bus.out_data;
    for (int i = 0; i < int'(hold); i++) begin
      bus.in_valid = 1'(i % 2);
      bus.in_data  = WIDTH'($urandom);
      bus.in_steps = STEP_W'($urandom_range(0, 20));
      tick();
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", 64'(bus.out_data), 64'(snap));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_valid", 64'(bus.out_valid), 64'd0);
    check("post_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_steps  = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    rst_n = 1'b1;
    check("rel_in_ready_pre", 64'(bus.in_ready), 64'd0);
    tick();
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);

    run_op(32'd5, 3, 0);
    run_op(32'd4095, 10, 0);
    run_op(32'hFFFF_FFFF, 5, 0);
    run_op(32'd100, 0, 0);
    run_op(32'd0, 20, 0);
    run_op(32'd7, 2, 5);
    run_op(32'd4096, 4, 1);

    // Reset mid-operation aborts everything immediately.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd10;
    bus.in_steps = STEP_W'(8);
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_out_data", 64'(bus.out_data), 64'd0);
    check("abort_out_steps", 64'(bus.out_steps), 64'd0);
    check("abort_out_sat", 64'(bus.out_saturated), 64'd0);
    tick();
    check("abort_hold_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    check("abort_rel_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(32'd1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] d;
      case ($urandom_range(0, 3))
        0: d = WIDTH'($urandom_range(0, 40));
        1: d = WIDTH'(THRESHOLD - 20 + $urandom_range(0, 30));
        2: d = WIDTH'($urandom);
        default: d = 32'hFFFF_FFFF - WIDTH'($urandom_range(0, 3));
      endcase
      run_op(d, $urandom_range(0, 31), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
